i2c_cmd_master: RTL
===================

// Module: i2c_cmd_master
// PURPOSE
//  Serialises the 24-bit codec configuration word held by the i2c_data PIO onto the I2C bus.
//  One command is {slave_addr+R/W[23:16], reg_addr[15:8], reg_data[7:0]}.
//  Issues START, three bytes MSB-first each followed by an ACK slot, then STOP.
//  Sits between the Qsys PIO outputs (data word + go bit) and the audio-codec I2C pins.
//  Status is returned to software through a PIO input.
// PARAMETERS
//  QUARTER_CYCLES  125  clk cycles per quarter SCL period (50 MHz / (4*125) = 100 kHz SCL)
// PORTS
//  clk          in   1   system clock; everything runs in this single domain
//  reset        in   1   asynchronous, active-high reset
//  cmd_data     in   24  command word from the i2c_data PIO
//  cmd_go       in   1   start request; its rising edge launches one transaction
//  i2c_sclk     out  1   SCL, push-pull; no clock stretching supported
//  i2c_sdat_oe  out  1   1 = drive SDA low, 0 = release SDA (pin is open-drain at top level)
//  i2c_sdat_in  in   1   SDA pin value, already synchronised at the top level
//  busy         out  1   high while a transaction is in progress
//  done         out  1   one-cycle pulse when a transaction ends (success or NACK)
//  ack_err      out  1   sticky; set when any ACK slot samples SDA=1
// BEHAVIOUR
//  Reset values and reset behaviour
//  - Reset (async): i2c_sclk=1, i2c_sdat_oe=0, busy=0, done=0, ack_err=0, FSM=IDLE, counters=0.
//  - Reset mid-transaction aborts at once with no STOP generated. Software re-issues the command.
//  Start detection
//  - cmd_go is registered once; start = go & ~go_q.
//  - Start is accepted only in IDLE. Edges seen while busy are dropped, not queued.
//  - On accept: cmd_data is latched into the shift register and ack_err is cleared.
//  - busy=1 from the cycle after the edge until the cycle done pulses.
//  Timing
//  - A quarter tick counter counts 0..QUARTER_CYCLES-1 and runs only while busy.
//  - Each bus phase lasts 4 quarters (q0..q3).
//  FSM states: IDLE, START, BIT, ACK, STOP, FIN
//  - START: q0-q1 SCL=1, SDA released; q2-q3 SCL=1, SDA driven low. Then -> BIT.
//  - BIT: q0 SCL=0, SDA set from shift MSB (oe = ~bit); q1 SCL=0; q2-q3 SCL=1.
//    After q3 the shift register moves left and bit_cnt increments.
//    After bit 7 -> ACK.
//  - ACK: SDA released; SCL as in BIT; i2c_sdat_in is sampled on the last clk of q2.
//    If sample=1: ack_err<=1 and -> STOP; remaining bytes are not sent.
//    Otherwise, after byte 2 -> STOP, else byte_cnt++ and -> BIT.
//  - STOP: q0 SCL=0, SDA low; q1 SCL=1, SDA low; q2-q3 SCL=1, SDA released.
//  - FIN: done=1 for one cycle, busy=0, -> IDLE.
//  Latency and widths
//  - Full transaction = 116 quarters (4 + 27*4 + 4) = 116*QUARTER_CYCLES clks from the first
//    busy cycle to the done pulse.
//  - bit_cnt is 3 bits and byte_cnt is 2 bits, with no wrap beyond byte 2.
//  - The tick counter is $clog2(QUARTER_CYCLES) bits wide.
//  Data stability
//  - SDA changes only while SCL=0, except at START/STOP.
//  - cmd_data changes after accept have no effect.
// TESTING (QUARTER_CYCLES=4 in bench; bench I2C slave model monitors the bus)
//  1. Assert reset mid-idle and deassert -> sclk=1, sdat_oe=0, busy=0, done=0, ack_err=0.
//  2. cmd_data=24'h341E00, go 0->1, slave ACKs all bytes
//     -> monitor decodes START, 34, 1E, 00, STOP; done 464 clks after busy rises; ack_err=0.
//  3. cmd_data=24'h340C00, slave NACKs byte 2 -> ack_err=1, only 34, 0C on bus, STOP follows;
//     done pulses; ack_err stays 1 until next accept.
//  4. Hold cmd_go high, toggle it while busy, and change cmd_data to 24'hFFFFFF mid-run
//     -> exactly one transaction, bytes are the originally latched value.
//  5. Assert reset during byte 2, bit 3 -> next edge: sclk=1, sdat_oe=0, busy=0;
//     a new go then completes a full clean transaction.
//  6. After a NACK run, give a go edge 1 clk after done -> second transaction starts,
//     ack_err cleared in accept cycle, ends with ack_err=0.

Source files
------------

// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: serialises one 24-bit codec command {addr+rw, reg, data}
// onto I2C as START, three bytes with ACK slots, STOP. Push-pull SCL, open-drain
// SDA via an output-enable. Bus pins are registered, so both lag the FSM by one clk.
module i2c_cmd_master #(
    parameter int QUARTER_CYCLES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] cmd_data,
    input  logic        cmd_go,
    output logic        i2c_sclk,
    output logic        i2c_sdat_oe,
    input  logic        i2c_sdat_in,
    output logic        busy,
    output logic        done,
    output logic        ack_err
);

    localparam int QW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QUARTER_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, FIN} state_t;

    state_t        state, state_nxt;
    logic          go_q;
    logic          start;
    logic          accept;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
    logic          q_end;
    logic          phase_end;
    logic          ack_smp;
    logic          sclk_nxt;
    logic          oe_nxt;

    assign start     = cmd_go & ~go_q;
    assign accept    = (state == IDLE) && start;
    assign q_end     = (qcnt == QLAST);
    assign phase_end = q_end && (quarter == 2'd3);
    // ACK is sampled on the last clk of q2, while SCL has been high for a while
    assign ack_smp   = (state == ACK) && q_end && (quarter == 2'd2);
    assign busy      = (state != IDLE) && (state != FIN);
    assign done      = (state == FIN);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and bus-pin decode for the current phase/quarter
    always_comb begin
        state_nxt = state;
        sclk_nxt  = 1'b1;
        oe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = START;
            end
            START: begin
                // SDA falls in the second half while SCL stays high
                oe_nxt = quarter[1];
                if (phase_end) state_nxt = BIT;
            end
            BIT: begin
                sclk_nxt = quarter[1];
                oe_nxt   = ~shift[23];
                if (phase_end && bit_cnt == 3'd7) state_nxt = ACK;
            end
            ACK: begin
                sclk_nxt = quarter[1];
                // ack_err was set on the sample clk of this same slot on a NACK
                if (phase_end) begin
                    if (ack_err || byte_cnt == 2'd2) state_nxt = STOP;
                    else                             state_nxt = BIT;
                end
            end
            STOP: begin
                // SDA held low while SCL rises, then released with SCL high
                sclk_nxt = (quarter != 2'd0);
                oe_nxt   = ~quarter[1];
                if (phase_end) state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Go-edge detector register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) go_q <= 1'b0;
        else       go_q <= cmd_go;
    end

    // Quarter tick counter and quarter index; free-running only while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qcnt    <= '0;
            quarter <= 2'd0;
        end else if (accept) begin
            qcnt    <= '0;
            quarter <= 2'd0;
        end else if (busy) begin
            qcnt <= q_end ? '0 : qcnt + 1'b1;
            if (q_end) quarter <= quarter + 2'd1;
        end
    end

    // Command latch, bit/byte counters and sticky ACK error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift    <= '0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            ack_err  <= 1'b0;
        end else if (accept) begin
            shift    <= cmd_data;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            ack_err  <= 1'b0;
        end else begin
            if (state == BIT && phase_end) begin
                shift   <= {shift[22:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == ACK && phase_end && !ack_err && byte_cnt != 2'd2)
                byte_cnt <= byte_cnt + 2'd1;
            if (ack_smp && i2c_sdat_in)
                ack_err <= 1'b1;
        end
    end

    // Registered bus pins so SCL/SDA never glitch on state decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i2c_sclk    <= 1'b1;
            i2c_sdat_oe <= 1'b0;
        end else begin
            i2c_sclk    <= sclk_nxt;
            i2c_sdat_oe <= oe_nxt;
        end
    end

endmodule
